// File: rtl/clock12_defs_pkg.sv
// Shared clock12 definitions: set-mode state encoding and hour/minute limits,
// also used by the display decoder.
package clock12_defs_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_SET_HOUR = 2'd1,
    ST_SET_MIN  = 2'd2,
    ST_SET_AMPM = 2'd3
  } set_state_e;

  localparam logic [3:0] HOUR_FIRST   = 4'd1;
  localparam logic [3:0] HOUR_LAST    = 4'd12;
  localparam logic [3:0] HOUR_PM_FLIP = 4'd11;
  localparam logic [5:0] MIN_LAST     = 6'd59;
  localparam logic [5:0] SEC_LAST     = 6'd59;

  // 12-hour dial: 12 wraps to 1
  function automatic logic [3:0] hour_inc(input logic [3:0] h);
    return (h == HOUR_LAST) ? HOUR_FIRST : h + 4'd1;
  endfunction

  function automatic logic [5:0] wrap60_inc(input logic [5:0] v);
    return (v == MIN_LAST) ? 6'd0 : v + 6'd1;
  endfunction

endpackage

// File: rtl/clock12_tick_gen.sv
// 1 Hz prescaler: one-cycle tick every CLK_HZ cycles; clear/hold force the
// count back to zero.
module clock12_tick_gen #(
  parameter int CLK_HZ = 50000000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic hold,
  output logic tick
);

  localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_HZ - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || hold || (cnt_q == CNT_LAST)) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign tick = !hold && (cnt_q == CNT_LAST);

endmodule

// File: rtl/clock12_set_controller.sv
// 12-hour clock with RUN/SET_HOUR/SET_MIN/SET_AMPM edit controller.
// Optional macro CLOCK12_BLINK_EN enables the field-blink counter.
module clock12_set_controller
  import clock12_defs_pkg::*;
#(
  parameter int CLK_HZ = 50000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       is_on,
  input  logic       btn_mode,
  input  logic       btn_up,
  output logic [1:0] current_set_state,
  output logic       set_isPM,
  output logic [3:0] set_hour,
  output logic [5:0] set_min,
  output logic [3:0] cur_hour,
  output logic [5:0] cur_min,
  output logic [5:0] cur_sec,
  output logic       cur_isPM,
  output logic       blink
);

  set_state_e state_q, state_d;
  logic [3:0] set_hour_q, set_hour_d, cur_hour_q, cur_hour_d;
  logic [5:0] set_min_q, set_min_d, cur_min_q, cur_min_d, cur_sec_q, cur_sec_d;
  logic       set_pm_q, set_pm_d, cur_pm_q, cur_pm_d;
  logic       blink_q, blink_d;
  logic       tick, commit;

  clock12_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (commit),
    .hold    (state_q != ST_RUN),
    .tick    (tick)
  );

  always_comb begin
    state_d    = state_q;
    set_hour_d = set_hour_q;
    set_min_d  = set_min_q;
    set_pm_d   = set_pm_q;
    cur_hour_d = cur_hour_q;
    cur_min_d  = cur_min_q;
    cur_sec_d  = cur_sec_q;
    cur_pm_d   = cur_pm_q;
    commit     = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (tick) begin
          cur_sec_d = wrap60_inc(cur_sec_q);
          if (cur_sec_q == SEC_LAST) begin
            cur_min_d = wrap60_inc(cur_min_q);
            if (cur_min_q == MIN_LAST) begin
              cur_hour_d = hour_inc(cur_hour_q);
              if (cur_hour_q == HOUR_PM_FLIP) cur_pm_d = ~cur_pm_q;
            end
          end
        end
        // the edit starts from the pre-edge running time
        if (is_on && btn_mode) begin
          set_hour_d = cur_hour_q;
          set_min_d  = cur_min_q;
          set_pm_d   = cur_pm_q;
          state_d    = ST_SET_HOUR;
        end
      end
      default: begin
        if (!is_on) begin
          state_d = ST_RUN;
        end else if (btn_mode) begin
          case (state_q)
            ST_SET_HOUR: state_d = ST_SET_MIN;
            ST_SET_MIN:  state_d = ST_SET_AMPM;
            default: begin
              commit     = 1'b1;
              cur_hour_d = set_hour_q;
              cur_min_d  = set_min_q;
              cur_pm_d   = set_pm_q;
              cur_sec_d  = 6'd0;
              state_d    = ST_RUN;
            end
          endcase
        end else if (btn_up) begin
          case (state_q)
            ST_SET_HOUR: set_hour_d = hour_inc(set_hour_q);
            ST_SET_MIN:  set_min_d  = wrap60_inc(set_min_q);
            default:     set_pm_d   = ~set_pm_q;
          endcase
        end
      end
    endcase
  end

`ifdef CLOCK12_BLINK_EN
  localparam int BLINK_HALF = (CLK_HZ / 2 > 0) ? CLK_HZ / 2 : 1;
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

  logic [BW-1:0] blink_cnt_q, blink_cnt_d;

  always_comb begin
    blink_d     = blink_q;
    blink_cnt_d = blink_cnt_q + 1'b1;
    if (state_q == ST_RUN) begin
      blink_d     = 1'b1;
      blink_cnt_d = '0;
    end else if (blink_cnt_q == BLINK_LAST) begin
      blink_d     = ~blink_q;
      blink_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) blink_cnt_q <= '0;
    else          blink_cnt_q <= blink_cnt_d;
  end
`else
  always_comb blink_d = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_RUN;
      set_hour_q <= HOUR_LAST;
      set_min_q  <= 6'd0;
      set_pm_q   <= 1'b0;
      cur_hour_q <= HOUR_LAST;
      cur_min_q  <= 6'd0;
      cur_sec_q  <= 6'd0;
      cur_pm_q   <= 1'b0;
      blink_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      set_hour_q <= set_hour_d;
      set_min_q  <= set_min_d;
      set_pm_q   <= set_pm_d;
      cur_hour_q <= cur_hour_d;
      cur_min_q  <= cur_min_d;
      cur_sec_q  <= cur_sec_d;
      cur_pm_q   <= cur_pm_d;
      blink_q    <= blink_d;
    end
  end

  assign current_set_state = state_q;
  assign set_hour          = set_hour_q;
  assign set_min           = set_min_q;
  assign set_isPM          = set_pm_q;
  assign cur_hour          = cur_hour_q;
  assign cur_min           = cur_min_q;
  assign cur_sec           = cur_sec_q;
  assign cur_isPM          = cur_pm_q;
  assign blink             = blink_q;

endmodule
